// File: rtl/pattern_scan_arbiter.sv
// pattern_scan_arbiter
//   Round-robin scheduler that shares one bit-serial pattern detector among
//   NREQ requesters. A granted word is streamed MSB-first through a PAT_W-bit
//   history register. Overlapping matches are counted, and the count is
//   reported together with a one-cycle done pulse. The detector state is
//   cleared on every grant, so matches never span two requesters' words.
//
// Ports
//   clk            : single clock, rising edge
//   rst            : synchronous active-high reset
//   req_i          : per-requester request level
//   data_i         : requester k word at [k*WORD_W +: WORD_W]
//   cfg_we_i       : pattern write strobe (honoured in IDLE only)
//   pattern_cfg_i  : new pattern value
//   gnt_o          : one-hot grant/accept pulse
//   busy_o         : high while a word is being scanned
//   match_o        : one pulse per detected match
//   done_o         : one-cycle completion pulse
//   done_id_o      : index of the completed requester
//   match_cnt_o    : match count of the completed word, held until next done
module pattern_scan_arbiter #(
    parameter int               NREQ    = 4,
    parameter int               WORD_W  = 8,
    parameter int               PAT_W   = 4,
    parameter int               CNT_W   = 4,
    parameter logic [PAT_W-1:0] PAT_RST = 4'b1011
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NREQ-1:0]               req_i,
    input  logic [NREQ*WORD_W-1:0]        data_i,
    input  logic                          cfg_we_i,
    input  logic [PAT_W-1:0]              pattern_cfg_i,
    output logic [NREQ-1:0]               gnt_o,
    output logic                          busy_o,
    output logic                          match_o,
    output logic                          done_o,
    output logic [$clog2(NREQ)-1:0]       done_id_o,
    output logic [CNT_W-1:0]              match_cnt_o
);

    localparam int ID_W   = $clog2(NREQ);
    localparam int IDX_W  = $clog2(WORD_W);
    localparam int FILL_W = $clog2(PAT_W + 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t              state_q, state_d;
    logic [NREQ-1:0]     gnt_q, gnt_d;
    logic                busy_q, busy_d;
    logic                match_q, match_d;
    logic                done_q, done_d;
    logic [ID_W-1:0]     done_id_q, done_id_d;
    logic [CNT_W-1:0]    match_cnt_q, match_cnt_d;
    logic [PAT_W-1:0]    pattern_q, pattern_d;
    logic [ID_W-1:0]     rr_q, rr_d;

    logic [WORD_W-1:0]   word_q, word_d;
    logic [PAT_W-1:0]    hist_q, hist_d;
    logic [FILL_W-1:0]   fill_q, fill_d;
    logic [CNT_W-1:0]    mcnt_q, mcnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [ID_W-1:0]     id_q, id_d;

    // Round-robin pick: first requesting index at or above rr_q, with wrap.
    logic                found;
    logic [ID_W-1:0]     pick;
    logic [ID_W-1:0]     pick_next;
    int                  cand;

    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = 0;
        for (int i = 0; i < NREQ; i++) begin
            cand = (int'(rr_q) + i) % NREQ;
            if (!found && req_i[cand]) begin
                found = 1'b1;
                pick  = ID_W'(cand);
            end
        end
        pick_next = (int'(pick) + 1 == NREQ) ? '0 : ID_W'(int'(pick) + 1);
    end

    // One step of the bit-serial detector for the current bit.
    logic                cur_bit;
    logic [PAT_W:0]      hist_ext;
    logic [PAT_W-1:0]    hist_new;
    logic [FILL_W-1:0]   fill_new;
    logic                hit;
    logic [CNT_W-1:0]    mcnt_new;

    always_comb begin
        cur_bit  = word_q[idx_q];
        hist_ext = {hist_q, cur_bit};
        hist_new = hist_ext[PAT_W-1:0];
        fill_new = (fill_q == FILL_W'(PAT_W)) ? fill_q : fill_q + FILL_W'(1);
        // A match needs a full history window, counting the bit just shifted.
        hit      = (fill_new == FILL_W'(PAT_W)) && (hist_new == pattern_q);
        mcnt_new = (hit && (mcnt_q != '1)) ? mcnt_q + CNT_W'(1) : mcnt_q;
    end

    always_comb begin
        state_d     = state_q;
        gnt_d       = '0;
        busy_d      = busy_q;
        match_d     = 1'b0;
        done_d      = 1'b0;
        done_id_d   = done_id_q;
        match_cnt_d = match_cnt_q;
        pattern_d   = pattern_q;
        rr_d        = rr_q;
        word_d      = word_q;
        hist_d      = hist_q;
        fill_d      = fill_q;
        mcnt_d      = mcnt_q;
        idx_d       = idx_q;
        id_d        = id_q;

        case (state_q)
            IDLE: begin
                // A pattern write takes the whole cycle; any request waits.
                if (cfg_we_i) begin
                    pattern_d = pattern_cfg_i;
                end else if (found) begin
                    gnt_d   = NREQ'(1) << pick;
                    word_d  = data_i[pick*WORD_W +: WORD_W];
                    id_d    = pick;
                    rr_d    = pick_next;
                    hist_d  = '0;
                    fill_d  = '0;
                    mcnt_d  = '0;
                    idx_d   = IDX_W'(WORD_W - 1);
                    busy_d  = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                hist_d  = hist_new;
                fill_d  = fill_new;
                mcnt_d  = mcnt_new;
                match_d = hit;
                idx_d   = idx_q - IDX_W'(1);
                if (idx_q == '0) begin
                    done_d      = 1'b1;
                    done_id_d   = id_q;
                    match_cnt_d = mcnt_new;
                    busy_d      = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            busy_q      <= 1'b0;
            match_q     <= 1'b0;
            done_q      <= 1'b0;
            done_id_q   <= '0;
            match_cnt_q <= '0;
            pattern_q   <= PAT_RST;
            rr_q        <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            busy_q      <= busy_d;
            match_q     <= match_d;
            done_q      <= done_d;
            done_id_q   <= done_id_d;
            match_cnt_q <= match_cnt_d;
            pattern_q   <= pattern_d;
            rr_q        <= rr_d;
        end
    end

    // Scan datapath: every field is reinitialised on grant, so no reset.
    always_ff @(posedge clk) begin
        word_q <= word_d;
        hist_q <= hist_d;
        fill_q <= fill_d;
        mcnt_q <= mcnt_d;
        idx_q  <= idx_d;
        id_q   <= id_d;
    end

    assign gnt_o       = gnt_q;
    assign busy_o      = busy_q;
    assign match_o     = match_q;
    assign done_o      = done_q;
    assign done_id_o   = done_id_q;
    assign match_cnt_o = match_cnt_q;

endmodule

// File: tb/tb_pattern_scan_arbiter.sv
// tb_pattern_scan_arbiter
//   Directed-vector bench for pattern_scan_arbiter (NREQ=4, WORD_W=8,
//   PAT_W=4, CNT_W=4). Inputs change 1 ns after a rising edge and outputs are
//   sampled at the same point, well away from the active edge.
module tb_pattern_scan_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] data;
    logic        cfg_we;
    logic [3:0]  pat_cfg;
    logic [3:0]  gnt;
    logic        busy;
    logic        match;
    logic        done;
    logic [1:0]  done_id;
    logic [3:0]  match_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    pattern_scan_arbiter #(
        .NREQ(4), .WORD_W(8), .PAT_W(4), .CNT_W(4), .PAT_RST(4'b1011)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_i        (req),
        .data_i       (data),
        .cfg_we_i     (cfg_we),
        .pattern_cfg_i(pat_cfg),
        .gnt_o        (gnt),
        .busy_o       (busy),
        .match_o      (match),
        .done_o       (done),
        .done_id_o    (done_id),
        .match_cnt_o  (match_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 4'hF; data = '0; cfg_we = 1'b0; pat_cfg = '0;
        for (int c = 0; c < 2; c++) begin
            tick();
            n_checks++;
            if ({gnt, busy, match, done, done_id, match_cnt} !== 13'd0) begin
                n_fail++;
                $display("FAIL reset_outputs cycle %0d: got %b expected all zero", c,
                         {gnt, busy, match, done, done_id, match_cnt});
            end
        end
        rst = 1'b0;
        tick();
        n_checks++;
        if (gnt !== 4'b0001) begin
            n_fail++; $display("FAIL reset_first_grant: got %b expected 0001", gnt);
        end
        req = 4'h0;
        repeat (8) tick();
        n_checks++;
        if (done !== 1'b1 || match_cnt !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_scan_done: done=%b cnt=%0d expected done=1 cnt=0", done, match_cnt);
        end
        tick();
    endtask

    task automatic test_single_scan();
        req = 4'b0001; data[7:0] = 8'b1011_0110;
        tick();
        n_checks++;
        if (gnt !== 4'b0001 || busy !== 1'b1) begin
            n_fail++; $display("FAIL single_grant: gnt=%b busy=%b expected 0001/1", gnt, busy);
        end
        req = 4'b0000;
        for (int n = 1; n <= 8; n++) begin
            tick();
            n_checks++;
            if (match !== ((n == 4) || (n == 7))) begin
                n_fail++; $display("FAIL single_match after E%0d: got %b expected %b", n, match, (n == 4) || (n == 7));
            end
            n_checks++;
            if (gnt !== 4'b0000 || done !== (n == 8)) begin
                n_fail++; $display("FAIL single_gnt_done after E%0d: gnt=%b done=%b", n, gnt, done);
            end
        end
        n_checks++;
        if (done_id !== 2'd0 || match_cnt !== 4'd2 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_result: id=%0d cnt=%0d busy=%b expected 0/2/0", done_id, match_cnt, busy);
        end
        tick();
        n_checks++;
        if (done !== 1'b0 || match_cnt !== 4'd2) begin
            n_fail++; $display("FAIL single_hold: done=%b cnt=%0d expected 0/2", done, match_cnt);
        end
    endtask

    task automatic test_overlap();
        cfg_we = 1'b1; pat_cfg = 4'b1111;
        tick();
        cfg_we = 1'b0; req = 4'b0010; data[15:8] = 8'hFF;
        tick();
        n_checks++;
        if (gnt !== 4'b0010) begin
            n_fail++; $display("FAIL overlap_grant: got %b expected 0010", gnt);
        end
        req = 4'b0000;
        for (int n = 1; n <= 8; n++) begin
            tick();
            n_checks++;
            if (match !== (n >= 4)) begin
                n_fail++; $display("FAIL overlap_match after E%0d: got %b expected %b", n, match, n >= 4);
            end
        end
        n_checks++;
        if (done !== 1'b1 || done_id !== 2'd1 || match_cnt !== 4'd5) begin
            n_fail++;
            $display("FAIL overlap_result: done=%b id=%0d cnt=%0d expected 1/1/5", done, done_id, match_cnt);
        end
        tick();
    endtask

    task automatic test_round_robin();
        rst = 1'b1;
        tick();
        rst = 1'b0; req = 4'hF; data = '0;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_checks++;
            if (gnt !== (4'b0001 << k)) begin
                n_fail++; $display("FAIL rr_grant %0d: got %b expected %b", k, gnt, 4'b0001 << k);
            end
            req[k] = 1'b0;
            repeat (8) tick();
            n_checks++;
            if (done !== 1'b1 || done_id !== 2'(k) || gnt !== 4'b0000) begin
                n_fail++;
                $display("FAIL rr_done %0d: done=%b id=%0d gnt=%b", k, done, done_id, gnt);
            end
        end
        req = 4'b0101;
        tick();
        n_checks++;
        if (gnt !== 4'b0001) begin
            n_fail++; $display("FAIL rr_reraise_first: got %b expected 0001", gnt);
        end
        req[0] = 1'b0;
        repeat (8) tick();
        tick();
        n_checks++;
        if (gnt !== 4'b0100) begin
            n_fail++; $display("FAIL rr_reraise_second: got %b expected 0100", gnt);
        end
        req[2] = 1'b0;
        repeat (8) tick();
        tick();
    endtask

    task automatic test_config_collision();
        cfg_we = 1'b1; pat_cfg = 4'b0000; req = 4'b1000; data[31:24] = 8'h00;
        tick();
        n_checks++;
        if (gnt !== 4'b0000 || busy !== 1'b0) begin
            n_fail++; $display("FAIL cfg_slip: gnt=%b busy=%b expected 0000/0", gnt, busy);
        end
        cfg_we = 1'b0;
        tick();
        n_checks++;
        if (gnt !== 4'b1000) begin
            n_fail++; $display("FAIL cfg_late_grant: got %b expected 1000", gnt);
        end
        req = 4'b0000;
        for (int n = 1; n <= 8; n++) begin
            tick();
            if (n == 2) begin
                cfg_we = 1'b1; pat_cfg = 4'b1010;
            end else begin
                cfg_we = 1'b0;
            end
        end
        n_checks++;
        if (done !== 1'b1 || done_id !== 2'd3 || match_cnt !== 4'd5) begin
            n_fail++;
            $display("FAIL cfg_first_scan: done=%b id=%0d cnt=%0d expected 1/3/5", done, done_id, match_cnt);
        end
        req = 4'b1000;
        tick();
        n_checks++;
        if (gnt !== 4'b1000) begin
            n_fail++; $display("FAIL cfg_second_grant: got %b expected 1000", gnt);
        end
        req = 4'b0000;
        repeat (8) tick();
        n_checks++;
        if (done !== 1'b1 || match_cnt !== 4'd5) begin
            n_fail++;
            $display("FAIL cfg_drop_in_shift: done=%b cnt=%0d expected 1/5", done, match_cnt);
        end
        tick();
    endtask

    task automatic test_reset_mid_scan();
        logic saw_done;
        req = 4'b0010; data[15:8] = 8'hB0;
        tick();
        n_checks++;
        if (gnt !== 4'b0010) begin
            n_fail++; $display("FAIL midrst_grant: got %b expected 0010", gnt);
        end
        req = 4'b0000;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || match !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_outputs: busy=%b done=%b match=%b expected 0/0/0", busy, done, match);
        end
        rst = 1'b0;
        saw_done = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (done) saw_done = 1'b1;
        end
        n_checks++;
        if (saw_done !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL midrst_no_done: saw_done=%b busy=%b expected 0/0", saw_done, busy);
        end
        data = {8'h00, 8'h00, 8'h00, 8'b1011_1011};
        req = 4'hF;
        tick();
        n_checks++;
        if (gnt !== 4'b0001) begin
            n_fail++; $display("FAIL midrst_rr_restart: got %b expected 0001", gnt);
        end
        req = 4'h0;
        repeat (8) tick();
        n_checks++;
        if (done !== 1'b1 || done_id !== 2'd0 || match_cnt !== 4'd2) begin
            n_fail++;
            $display("FAIL midrst_pattern_restored: done=%b id=%0d cnt=%0d expected 1/0/2", done, done_id, match_cnt);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_single_scan();
        test_overlap();
        test_round_robin();
        test_config_collision();
        test_reset_mid_scan();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
